alu_control_mdu: RTL

ALU_CONTROL_MDU -- requirements
Module: alu_control_mdu

---
 rtl/alu_pkg.sv | 38 +++
 rtl/mdu_iter.sv | 42 ++++
 rtl/alu_control_mdu.sv | 135 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU select codes, ALUOp classes, R-type funct codes and MDU state encoding
package alu_pkg;
    localparam logic [3:0] SIG_ADD  = 4'd0;
    localparam logic [3:0] SIG_SUB  = 4'd1;
    localparam logic [3:0] SIG_AND  = 4'd2;
    localparam logic [3:0] SIG_OR   = 4'd3;
    localparam logic [3:0] SIG_NOR  = 4'd4;
    localparam logic [3:0] SIG_SLT  = 4'd5;
    localparam logic [3:0] SIG_SLL  = 4'd6;
    localparam logic [3:0] SIG_SRL  = 4'd7;
    localparam logic [3:0] SIG_MFHI = 4'd8;
    localparam logic [3:0] SIG_MFLO = 4'd9;
    localparam logic [3:0] SIG_MDU  = 4'd15;

    localparam logic [2:0] OP_MEM   = 3'b000;
    localparam logic [2:0] OP_BR    = 3'b001;
    localparam logic [2:0] OP_RTYPE = 3'b010;
    localparam logic [2:0] OP_ANDI  = 3'b011;
    localparam logic [2:0] OP_ORI   = 3'b100;
    localparam logic [2:0] OP_SLTI  = 3'b111;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} mdu_state_t;
endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: one-bit-per-cycle shift-add multiply / restoring divide on unsigned magnitudes
// ports: clk, rst_n; load/div/a/b capture a new op; step advances one iteration;
//        nxt is the accumulator value the next step will hold ({hi,lo} or {rem,quot})
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               step,
    output logic [2*WIDTH-1:0] nxt
);
    logic               mode;
    logic [WIDTH-1:0]   m;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     sum, sh;
    logic [WIDTH-1:0]   diff;
    logic               ge;
    // multiply: multiplier sits in the low half and shifts out as the product shifts in
    assign sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    // divide: {rem, quot} shifts left, dividend bits enter the partial remainder
    assign sh   = acc[2*WIDTH-1:WIDTH-1];
    assign ge   = sh >= {1'b0, m};
    assign diff = ge ? WIDTH'(sh - {1'b0, m}) : sh[WIDTH-1:0];
    assign nxt  = mode ? {diff, acc[WIDTH-2:0], ge} : {sum, acc[WIDTH-1:1]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= 1'b0;
            m    <= '0;
            acc  <= '0;
        end else if (load) begin
            mode <= div;
            m    <= div ? b : a;
            acc  <= {{WIDTH{1'b0}}, div ? a : b};
        end else if (step) begin
            acc  <= nxt;
        end
    end
endmodule

// File: rtl/alu_control_mdu.sv
// alu_control_mdu: ALU control decode plus iterative multiply/divide unit with HI/LO
// ports: clk, rst_n (async low); valid_in/funct/ALUOp/opA/opB from EX; flush aborts MDU op;
//        ALUsignal/illegal registered decode; stall while MDU busy; hi/lo registers; md_done pulse
module alu_control_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 3,
    parameter int SIGW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic             flush,
    input  logic [5:0]       funct,
    input  logic [OPW-1:0]   ALUOp,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [SIGW-1:0]  ALUsignal,
    output logic             illegal,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             md_done
);
    localparam int CW = $clog2(WIDTH) + 1;
    mdu_state_t         state, state_n;
    logic [CW-1:0]      cnt;
    logic [3:0]         sig;
    logic               ill, md, neg_q, neg_r;
    logic               accept, start, dz, last, md_div, md_signed;
    logic [WIDTH-1:0]   a_mag, b_mag, q_res, r_res;
    logic [2*WIDTH-1:0] nxt, p_res;
    assign stall     = state != S_IDLE;
    assign accept    = valid_in & ~stall;
    assign md_div    = funct[1];
    assign md_signed = ~funct[0];
    assign start     = accept & md & ~flush;
    assign dz        = md_div & (opB == '0);
    assign last      = cnt == CW'(WIDTH - 1);
    assign a_mag     = (md_signed & opA[WIDTH-1]) ? -opA : opA;
    assign b_mag     = (md_signed & opB[WIDTH-1]) ? -opB : opB;
    // neg_q doubles as the product sign for multiplies
    assign p_res     = neg_q ? -nxt : nxt;
    assign q_res     = neg_q ? -nxt[WIDTH-1:0] : nxt[WIDTH-1:0];
    assign r_res     = neg_r ? -nxt[2*WIDTH-1:WIDTH] : nxt[2*WIDTH-1:WIDTH];

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk  (clk),
        .rst_n(rst_n),
        .load (start & ~dz),
        .div  (md_div),
        .a    (a_mag),
        .b    (b_mag),
        .step (stall),
        .nxt  (nxt)
    );

    always_comb begin
        sig = SIG_ADD;
        ill = 1'b0;
        md  = 1'b0;
        case (ALUOp)
            OPW'(OP_MEM):  sig = SIG_ADD;
            OPW'(OP_BR):   sig = SIG_SUB;
            OPW'(OP_ANDI): sig = SIG_AND;
            OPW'(OP_ORI):  sig = SIG_OR;
            OPW'(OP_SLTI): sig = SIG_SLT;
            OPW'(OP_RTYPE):
                case (funct)
                    F_ADD:  sig = SIG_ADD;
                    F_SUB:  sig = SIG_SUB;
                    F_AND:  sig = SIG_AND;
                    F_OR:   sig = SIG_OR;
                    F_NOR:  sig = SIG_NOR;
                    F_SLT:  sig = SIG_SLT;
                    F_SLL:  sig = SIG_SLL;
                    F_SRL:  sig = SIG_SRL;
                    F_MFHI: sig = SIG_MFHI;
                    F_MFLO: sig = SIG_MFLO;
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        sig = SIG_MDU;
                        md  = 1'b1;
                    end
                    default: ill = 1'b1;
                endcase
            default: ill = 1'b1;
        endcase
    end

    // divide-by-zero never leaves IDLE; it is answered directly at the accept edge
    always_comb begin
        state_n = flush ? S_IDLE :
                  (start & ~dz) ? (md_div ? S_DIV : S_MUL) :
                  (stall & last) ? S_IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUsignal <= '0;
            illegal   <= 1'b0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            md_done   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            if (accept) begin
                ALUsignal <= SIGW'(sig);
                illegal   <= ill;
            end
            if (start) begin
                cnt   <= '0;
                neg_q <= md_signed & (opA[WIDTH-1] ^ opB[WIDTH-1]);
                neg_r <= md_signed & opA[WIDTH-1];
            end else if (stall) begin
                cnt   <= cnt + CW'(1);
            end
            md_done <= (start & dz) | (stall & last & ~flush);
            if (start & dz) begin
                hi <= opA;
                lo <= '1;
            end else if (stall & last & ~flush) begin
                hi <= (state == S_DIV) ? r_res : p_res[2*WIDTH-1:WIDTH];
                lo <= (state == S_DIV) ? q_res : p_res[WIDTH-1:0];
            end
        end
    end
endmodule
